// File: rtl/sreg_wb_arbiter_if.sv
// Writeback bus between the producers, the scalar register file write port
// and the issue-stage scoreboard.
interface sreg_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 3,
   parameter int REG_COUNT  = 32
);
   logic [NUM_SRC-1:0]            wb_valid_i;
   logic [NUM_SRC*5-1:0]          wb_addr_i;
   logic [NUM_SRC*DATA_WIDTH-1:0] wb_data_i;
   logic [NUM_SRC-1:0]            wb_ready_o;
   logic [4:0]                    rd_addr_o;
   logic [DATA_WIDTH-1:0]         rd_data_o;
   logic                          reg_write_en_o;
   logic                          sb_set_i;
   logic [4:0]                    sb_set_addr_i;
   logic [REG_COUNT-1:0]          sb_busy_o;

   modport slave (
      input  wb_valid_i, wb_addr_i, wb_data_i, sb_set_i, sb_set_addr_i,
      output wb_ready_o, rd_addr_o, rd_data_o, reg_write_en_o, sb_busy_o
   );

   modport master (
      output wb_valid_i, wb_addr_i, wb_data_i, sb_set_i, sb_set_addr_i,
      input  wb_ready_o, rd_addr_o, rd_data_o, reg_write_en_o, sb_busy_o
   );
endinterface

// File: rtl/sreg_wb_arbiter.sv
// Round-robin writeback arbiter for the scalar register file, with a registered
// write stage and a pending-write scoreboard.
module sreg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 3,
   parameter int REG_COUNT  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   sreg_wb_arbiter_if.slave     bus
);
   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [PTR_W-1:0]      r_ptr;
   logic [4:0]            r_rdAddr;
   logic [DATA_WIDTH-1:0] r_rdData;
   logic                  r_writeEn;
   logic [REG_COUNT-1:0]  r_busy;

   logic                  w_found;
   logic [PTR_W-1:0]      w_grantIdx;
   logic [NUM_SRC-1:0]    w_grant;
   logic [4:0]            w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [PTR_W-1:0]      w_nextPtr;
   logic [REG_COUNT-1:0]  w_busyNext;

   // Scan from the pointer upward with wrap; first valid source wins.
   always_comb begin
      w_found    = 1'b0;
      w_grantIdx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!w_found && bus.wb_valid_i[(int'(r_ptr) + i) % NUM_SRC]) begin
            w_found    = 1'b1;
            w_grantIdx = PTR_W'((int'(r_ptr) + i) % NUM_SRC);
         end
      end
      if (rst) begin
         w_found = 1'b0;
      end
      w_grant = '0;
      if (w_found) begin
         w_grant[w_grantIdx] = 1'b1;
      end
   end

   assign w_addr    = bus.wb_addr_i[int'(w_grantIdx)*5 +: 5];
   assign w_data    = bus.wb_data_i[int'(w_grantIdx)*DATA_WIDTH +: DATA_WIDTH];
   assign w_nextPtr = (w_grantIdx == PTR_W'(NUM_SRC-1)) ? '0 : w_grantIdx + 1'b1;

   // Clear for the write now landing, then set, so a new producer wins a tie.
   always_comb begin
      w_busyNext = r_busy;
      if (r_writeEn) begin
         w_busyNext[r_rdAddr] = 1'b0;
      end
      if (bus.sb_set_i) begin
         w_busyNext[bus.sb_set_addr_i] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_rdAddr  <= '0;
         r_rdData  <= '0;
         r_writeEn <= 1'b0;
         r_busy    <= '0;
      end else begin
         r_busy <= w_busyNext;
         if (w_found) begin
            r_ptr     <= w_nextPtr;
            r_rdAddr  <= w_addr;
            r_rdData  <= w_data;
            r_writeEn <= (w_addr != 5'd0);
         end else begin
            r_writeEn <= 1'b0;
         end
      end
   end

   assign bus.wb_ready_o     = w_grant;
   assign bus.rd_addr_o      = r_rdAddr;
   assign bus.rd_data_o      = r_rdData;
   assign bus.reg_write_en_o = r_writeEn;
   assign bus.sb_busy_o      = r_busy;
endmodule
